// File: rtl/rpsc_pkg.sv
// Shared types and defaults for the RPSC high-voltage sequencer.
package rpsc_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    G1_UP   = 3'd1,
    AN_UP   = 3'd2,
    RUN     = 3'd3,
    AN_DOWN = 3'd4,
    FAULT   = 3'd5
  } seq_state_t;

  typedef enum logic [2:0] {
    NONE    = 3'd0,
    G1_PERM = 3'd1,
    AN_PERM = 3'd2,
    G1_LOST = 3'd3,
    AN_LOST = 3'd4,
    G1_TMO  = 3'd5,
    AN_TMO  = 3'd6,
    ILLEGAL = 3'd7
  } fault_code_t;

  localparam int G1_TIMEOUT_DEF = 192;
  localparam int AN_TIMEOUT_DEF = 384;
  localparam int OFF_DELAY_DEF  = 64;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Highest-priority interlock loss; callers tie unchecked inputs high.
  function automatic fault_code_t first_cause(input logic g1_on_perm, input logic an_perm,
                                              input logic g1_ok, input logic an_ok);
    if (!g1_on_perm) return G1_PERM;
    if (!an_perm)    return AN_PERM;
    if (!g1_ok)      return G1_LOST;
    if (!an_ok)      return AN_LOST;
    return NONE;
  endfunction

endpackage

// File: rtl/rpsc_seq_timer.sv
// Saturating state-dwell counter with sync clear and a terminal-count compare.
module rpsc_seq_timer #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] term,
  output logic         hit
);

  logic [W-1:0] count;

  // NOTE: sequential state is written with <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset || clr) count <= '0;
    else if (en && (count != '1)) count <= count + W'(1);
  end

  assign hit = (count == term);

endmodule

// File: rtl/rpsc_hv_sequencer.sv
// G1/anode power sequencer: staged bring-up, staged stop, first-fault latch.
module rpsc_hv_sequencer
  import rpsc_pkg::*;
#(
  parameter int G1_TIMEOUT = G1_TIMEOUT_DEF,
  parameter int AN_TIMEOUT = AN_TIMEOUT_DEF,
  parameter int OFF_DELAY  = OFF_DELAY_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_req,
  input  logic       stop_req,
  input  logic       fault_ack,
  input  logic       g1_on_perm,
  input  logic       g1_ok,
  input  logic       an_perm,
  input  logic       an_ok,
  output logic       g1_en,
  output logic       an_en,
  output logic       ready,
  output logic       fault,
  output logic [2:0] fault_code,
  output logic [2:0] state
);

  localparam int CNT_W = $clog2(max3(G1_TIMEOUT, AN_TIMEOUT, OFF_DELAY)) + 1;

  seq_state_t       state_q, state_d;
  fault_code_t      code_q, cause;
  logic [CNT_W-1:0] term;
  logic             tmr_hit;

  always_comb begin
    case (state_q)
      G1_UP:   term = CNT_W'(G1_TIMEOUT - 1);
      AN_UP:   term = CNT_W'(AN_TIMEOUT - 1);
      AN_DOWN: term = CNT_W'(OFF_DELAY - 1);
      default: term = '1;
    endcase
  end

  rpsc_seq_timer #(.W(CNT_W)) u_timer (
    .clk   (clk),
    .reset (reset),
    .clr   (state_d != state_q),
    .en    (state_q inside {G1_UP, AN_UP, AN_DOWN}),
    .term  (term),
    .hit   (tmr_hit)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      code_q  <= NONE;
    end else begin
      state_q <= state_d;
      if (state_q != FAULT && state_d == FAULT) code_q <= cause;
      else if (state_q == FAULT && state_d == IDLE) code_q <= NONE;
    end
  end

  // Fault causes outrank stop_req, which outranks ok/timeout progress.
  always_comb begin
    // NOTE: defaults first so no path leaves a variable unassigned (no latch).
    state_d = state_q;
    cause   = NONE;
    case (state_q)
      IDLE: if (start_req && g1_on_perm && an_perm) state_d = G1_UP;
      G1_UP: begin
        cause = first_cause(g1_on_perm, an_perm, 1'b1, 1'b1);
        if (cause == NONE) begin
          if (stop_req)     state_d = AN_DOWN;
          else if (g1_ok)   state_d = AN_UP;
          else if (tmr_hit) cause   = G1_TMO;
        end
      end
      AN_UP: begin
        cause = first_cause(g1_on_perm, an_perm, g1_ok, 1'b1);
        if (cause == NONE) begin
          if (stop_req)     state_d = AN_DOWN;
          else if (an_ok)   state_d = RUN;
          else if (tmr_hit) cause   = AN_TMO;
        end
      end
      RUN: begin
        cause = first_cause(g1_on_perm, an_perm, g1_ok, an_ok);
        if (cause == NONE && stop_req) state_d = AN_DOWN;
      end
      AN_DOWN: begin
        cause = first_cause(g1_on_perm, 1'b1, 1'b1, 1'b1);
        if (cause == NONE && tmr_hit) state_d = IDLE;
      end
      FAULT: if (fault_ack && g1_on_perm && an_perm) state_d = IDLE;
      default: cause = ILLEGAL;
    endcase
    if (cause != NONE) state_d = FAULT;
  end

  always_comb begin
    g1_en = 1'b0;
    an_en = 1'b0;
    ready = 1'b0;
    fault = 1'b0;
    case (state_q)
      G1_UP, AN_DOWN: g1_en = 1'b1;
      AN_UP: begin
        g1_en = 1'b1;
        an_en = 1'b1;
      end
      RUN: begin
        g1_en = 1'b1;
        an_en = 1'b1;
        ready = 1'b1;
      end
      FAULT:   fault = 1'b1;
      default: ;
    endcase
  end

  assign fault_code = code_q;
  assign state      = state_q;

endmodule

// File: tb/tb_rpsc_hv_sequencer.sv
// Scoreboard bench for rpsc_hv_sequencer: every cycle's expected outputs are queued then compared.
module tb_rpsc_hv_sequencer;
  import rpsc_pkg::*;

  logic       clk = 1'b0;
  logic       reset, start_req, stop_req, fault_ack;
  logic       g1_on_perm, g1_ok, an_perm, an_ok;
  logic       g1_en, an_en, ready, fault;
  logic [2:0] fault_code, state;

  typedef struct {
    string      name;
    logic [9:0] v;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  rpsc_hv_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .start_req  (start_req),
    .stop_req   (stop_req),
    .fault_ack  (fault_ack),
    .g1_on_perm (g1_on_perm),
    .g1_ok      (g1_ok),
    .an_perm    (an_perm),
    .an_ok      (an_ok),
    .g1_en      (g1_en),
    .an_en      (an_en),
    .ready      (ready),
    .fault      (fault),
    .fault_code (fault_code),
    .state      (state)
  );

  // Expected output vector {state, g1_en, an_en, ready, fault, fault_code}.
  function automatic logic [9:0] model(input seq_state_t s, input fault_code_t c);
    logic g1, an, rdy, flt;
    g1  = (s == G1_UP) || (s == AN_UP) || (s == RUN) || (s == AN_DOWN);
    an  = (s == AN_UP) || (s == RUN);
    rdy = (s == RUN);
    flt = (s == FAULT);
    return {s, g1, an, rdy, flt, c};
  endfunction

  function automatic logic [9:0] observed();
    return {state, g1_en, an_en, ready, fault, fault_code};
  endfunction

  task automatic push_exp(input string n, input seq_state_t s, input fault_code_t c);
    exp_t e;
    e.name = n;
    e.v    = model(s, c);
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet_inputs();
    reset      = 1'b0;
    start_req  = 1'b0;
    stop_req   = 1'b0;
    fault_ack  = 1'b0;
    g1_on_perm = 1'b1;
    an_perm    = 1'b1;
    g1_ok      = 1'b0;
    an_ok      = 1'b0;
  endtask

  // Unchecked setup: IDLE -> G1_UP -> AN_UP -> RUN in three edges.
  task automatic go_run();
    quiet_inputs();
    g1_ok     = 1'b1;
    an_ok     = 1'b1;
    start_req = 1'b1;
    tick();
    start_req = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset();
    exp_t e;
    quiet_inputs();
    reset = 1'b1;
    push_exp("reset", IDLE, NONE);
    tick();
    e = sb.pop_front();
    checks++;
    if (observed() !== e.v) begin
      errors++;
      $display("FAIL %s: got %b want %b", e.name, observed(), e.v);
    end
    reset = 1'b0;
  endtask

  task automatic test_start_blocked();
    exp_t e;
    quiet_inputs();
    for (int i = 0; i < 3; i++) begin
      an_perm    = (i != 0);
      g1_on_perm = (i != 1);
      start_req  = (i < 2);
      push_exp($sformatf("start_blocked[%0d]", i), IDLE, NONE);
      tick();
      e = sb.pop_front();
      checks++;
      if (observed() !== e.v) begin
        errors++;
        $display("FAIL %s: got %b want %b", e.name, observed(), e.v);
      end
    end
    quiet_inputs();
  endtask

  task automatic test_nominal_up();
    exp_t e;
    quiet_inputs();
    for (int i = 1; i <= 32; i++) begin
      start_req = (i == 1);
      g1_ok     = (i >= 11);
      an_ok     = (i >= 31);
      push_exp($sformatf("nominal_up[edge %0d]", i),
               (i < 11) ? G1_UP : (i < 31) ? AN_UP : RUN, NONE);
      tick();
      e = sb.pop_front();
      checks++;
      if (observed() !== e.v) begin
        errors++;
        $display("FAIL %s: got %b want %b", e.name, observed(), e.v);
      end
    end
  endtask

  task automatic test_interlock_run();
    exp_t e;
    go_run();
    for (int i = 0; i < 5; i++) begin
      g1_on_perm = (i >= 3);
      an_perm    = (i >= 3);
      an_ok      = (i == 0);
      fault_ack  = (i == 2) || (i == 3);
      push_exp($sformatf("interlock_run[%0d]", i),
               (i < 3) ? FAULT : IDLE, (i < 3) ? G1_PERM : NONE);
      tick();
      e = sb.pop_front();
      checks++;
      if (observed() !== e.v) begin
        errors++;
        $display("FAIL %s: got %b want %b", e.name, observed(), e.v);
      end
      fault_ack = 1'b0;
    end
    quiet_inputs();
  endtask

  task automatic test_g1_timeout();
    exp_t e;
    quiet_inputs();
    for (int i = 0; i <= 193; i++) begin
      start_req = (i == 0);
      fault_ack = (i == 193);
      push_exp($sformatf("g1_timeout[%0d]", i),
               (i < 192) ? G1_UP : (i < 193) ? FAULT : IDLE,
               (i == 192) ? G1_TMO : NONE);
      tick();
      e = sb.pop_front();
      checks++;
      if (observed() !== e.v) begin
        errors++;
        $display("FAIL %s: got %b want %b", e.name, observed(), e.v);
      end
    end
    quiet_inputs();
  endtask

  task automatic test_an_timeout();
    exp_t e;
    quiet_inputs();
    g1_ok = 1'b1;
    for (int i = 0; i <= 386; i++) begin
      start_req = (i == 0);
      fault_ack = (i == 386);
      push_exp($sformatf("an_timeout[%0d]", i),
               (i == 0) ? G1_UP : (i < 385) ? AN_UP : (i == 385) ? FAULT : IDLE,
               (i == 385) ? AN_TMO : NONE);
      tick();
      e = sb.pop_front();
      checks++;
      if (observed() !== e.v) begin
        errors++;
        $display("FAIL %s: got %b want %b", e.name, observed(), e.v);
      end
    end
    quiet_inputs();
  endtask

  task automatic test_normal_stop();
    exp_t e;
    go_run();
    for (int i = 0; i <= 65; i++) begin
      stop_req  = (i == 0) || (i == 10);
      start_req = (i == 5);
      push_exp($sformatf("normal_stop[k+%0d]", i), (i < 64) ? AN_DOWN : IDLE, NONE);
      tick();
      e = sb.pop_front();
      checks++;
      if (observed() !== e.v) begin
        errors++;
        $display("FAIL %s: got %b want %b", e.name, observed(), e.v);
      end
    end
    quiet_inputs();
  endtask

  task automatic test_g1_stop_then_perm_loss();
    exp_t e;
    quiet_inputs();
    for (int i = 0; i < 4; i++) begin
      start_req  = (i == 0);
      stop_req   = (i == 1);
      g1_on_perm = (i != 2);
      fault_ack  = (i == 3);
      push_exp($sformatf("g1_stop[%0d]", i),
               (i == 0) ? G1_UP : (i == 1) ? AN_DOWN : (i == 2) ? FAULT : IDLE,
               (i == 2) ? G1_PERM : NONE);
      tick();
      e = sb.pop_front();
      checks++;
      if (observed() !== e.v) begin
        errors++;
        $display("FAIL %s: got %b want %b", e.name, observed(), e.v);
      end
    end
    quiet_inputs();
  endtask

  task automatic test_simultaneous();
    exp_t e;
    go_run();
    for (int i = 0; i < 2; i++) begin
      stop_req  = (i == 0);
      an_ok     = 1'b0;
      fault_ack = (i == 1);
      push_exp($sformatf("stop_vs_an_loss[%0d]", i),
               (i == 0) ? FAULT : IDLE, (i == 0) ? AN_LOST : NONE);
      tick();
      e = sb.pop_front();
      checks++;
      if (observed() !== e.v) begin
        errors++;
        $display("FAIL %s: got %b want %b", e.name, observed(), e.v);
      end
    end
    quiet_inputs();
    g1_ok = 1'b1;
    for (int i = 0; i <= 386; i++) begin
      start_req = (i == 0);
      an_ok     = (i >= 385);
      push_exp($sformatf("ok_on_timeout[%0d]", i),
               (i == 0) ? G1_UP : (i < 385) ? AN_UP : RUN, NONE);
      tick();
      e = sb.pop_front();
      checks++;
      if (observed() !== e.v) begin
        errors++;
        $display("FAIL %s: got %b want %b", e.name, observed(), e.v);
      end
    end
  endtask

  task automatic test_reset_in_run();
    exp_t e;
    go_run();
    for (int i = 0; i < 2; i++) begin
      reset = (i == 0);
      push_exp($sformatf("reset_in_run[%0d]", i), IDLE, NONE);
      tick();
      e = sb.pop_front();
      checks++;
      if (observed() !== e.v) begin
        errors++;
        $display("FAIL %s: got %b want %b", e.name, observed(), e.v);
      end
    end
    quiet_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    quiet_inputs();
    test_reset();
    test_start_blocked();
    test_nominal_up();
    test_interlock_run();
    test_g1_timeout();
    test_an_timeout();
    test_normal_stop();
    test_g1_stop_then_perm_loss();
    test_simultaneous();
    test_reset_in_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rpsc_hv_sequencer.md
# rpsc_hv_sequencer

Power-up/power-down sequencer for the RPSC high-voltage chain. It enables the G1 grid supply first, waits for the card-2 G1 OK confirmation, then enables the anode supply and waits for anode OK. It tears down in reverse order on a stop request and latches the first fault on any interlock loss or timeout. It sits between the operator/host command interface and the card-2 interlock logic, which supplies the permission and OK signals it consumes.

## Interface
Parameters:
- G1_TIMEOUT, 192: cycles allowed in G1_UP for g1_ok to assert (3 s at the 64 Hz system tick).
- AN_TIMEOUT, 384: cycles allowed in AN_UP for an_ok to assert (6 s).
- OFF_DELAY, 64: cycles G1 stays enabled after the anode is disabled on a normal stop.

Ports:
- clk  in  1  system clock, 64 Hz tick domain.
- reset  in  1  synchronous, active-high.
- start_req  in  1  operator ON pulse; single cycle is sufficient.
- stop_req  in  1  operator OFF pulse.
- fault_ack  in  1  operator fault acknowledge.
- g1_on_perm  in  1  G1 permission, high = no G1 alarm.
- g1_ok  in  1  G1 supply confirmed stable.
- an_perm  in  1  anode permission (threshold and OT ready), high = permitted.
- an_ok  in  1  anode supply confirmed stable.
- g1_en  out  1  G1 supply enable.
- an_en  out  1  anode supply enable.
- ready  out  1  high only in RUN.
- fault  out  1  high only in FAULT.
- fault_code  out  3  latched first-fault code; 0 = none.
- state  out  3  current state encoding, for diagnostics.

## Operation
- States and encodings: IDLE=0, G1_UP=1, AN_UP=2, RUN=3, AN_DOWN=4, FAULT=5. Encodings 6–7 are illegal and go to FAULT with code 7.
- Outputs are decoded from the state register:
  - g1_en = G1_UP | AN_UP | RUN | AN_DOWN.
  - an_en = AN_UP | RUN.
- Reset values: state=IDLE, all outputs 0, fault_code=0, counter 0.
- IDLE:
  - start_req & g1_on_perm & an_perm → G1_UP.
  - start_req without both permissions is ignored; no fault is raised.
- G1_UP:
  - Loss of a permission → FAULT.
  - stop_req → AN_DOWN.
  - g1_ok → AN_UP.
  - counter == G1_TIMEOUT-1 with g1_ok low → FAULT, code 5.
- AN_UP:
  - Loss of a permission or of g1_ok → FAULT.
  - stop_req → AN_DOWN.
  - an_ok → RUN.
  - counter == AN_TIMEOUT-1 with an_ok low → FAULT, code 6.
- RUN:
  - Loss of any of g1_on_perm, an_perm, g1_ok, an_ok → FAULT.
  - stop_req → AN_DOWN.
- AN_DOWN:
  - g1_on_perm low → FAULT, code 1.
  - counter == OFF_DELAY-1 → IDLE.
  - start_req and stop_req are ignored.
- FAULT:
  - fault_ack & g1_on_perm & an_perm → IDLE, and fault_code clears to 0 on that transition.
  - fault_ack without both permissions is ignored.
- Fault code priority when several causes are true in the same cycle: g1_on_perm lost=1 > an_perm lost=2 > g1_ok lost=3 > an_ok lost=4 > G1 timeout=5 > AN timeout=6.
- Fault code latching: the code is written only on the transition into FAULT. Later causes never overwrite it.
- Per-cycle precedence: reset > fault causes > stop_req > progress (ok/timeout). A fault cause coincident with stop_req goes to FAULT.

## Timing
- Inputs are sampled at a clk rising edge; the state and decoded outputs change at that same edge. Latency from input to enable change is one edge.
- Counter:
  - Cleared on every state change.
  - Increments each cycle in G1_UP, AN_UP and AN_DOWN; held at 0 elsewhere.
  - Saturates at its maximum.
  - Width is $clog2 of the largest parameter, plus 1.
- A timeout fires on the edge where counter == TIMEOUT-1. Exactly TIMEOUT cycles are spent in the state.
- An ok arriving in the same cycle as the timeout wins, because timeout sits lowest in precedence.
- A normal stop from RUN gives an_en low at edge k and g1_en low at edge k+OFF_DELAY.
- A fault drops both enables at the same edge.
- Reset mid-operation (e.g. in RUN) gives IDLE and all outputs 0 at the next edge, with no staged shutdown.

## Structure
- Package rpsc_pkg holds:
  - typedef enum logic [2:0] seq_state_t.
  - typedef enum logic [2:0] fault_code_t (NONE, G1_PERM, AN_PERM, G1_LOST, AN_LOST, G1_TMO, AN_TMO, ILLEGAL).
  - Default timeout constants.
- Sub-module rpsc_seq_timer: counter with sync clear, count enable, saturation and a terminal-compare input. It is instantiated once, and the sequencer muxes the compare value per state.

## Test plan
- Nominal up: perms high, start_req pulse, g1_ok at cycle 10, an_ok 20 cycles later → g1_en at edge 1, an_en at edge 11, ready at edge 31, fault_code=0.
- G1 timeout: start with g1_ok held low → FAULT exactly 192 cycles after G1_UP entry, fault_code=5, both enables 0. fault_ack with perms high → IDLE, code 0.
- Interlock in RUN: g1_on_perm and an_perm drop in the same cycle → FAULT, code 1. A later an_ok drop leaves the code at 1. fault_ack while g1_on_perm is low is ignored.
- Normal stop: stop_req in RUN → an_en 0 next edge, g1_en 0 after 64 cycles, then IDLE. A start_req during AN_DOWN is ignored.
- Simultaneous: stop_req and an_ok loss in the same RUN cycle → FAULT, code 4. an_ok arriving on the AN_UP timeout cycle → RUN.
- Reset in RUN: reset pulse → IDLE, all outputs and fault_code 0 at the next edge.
